// File: rtl/example_regbank_pkg.sv
// Shared types for example_regbank: access modes, response record, access-field helper.
package example_regbank_pkg;

    typedef enum logic [1:0] {
        ACC_RW  = 2'd0,
        ACC_RO  = 2'd1,
        ACC_W1C = 2'd2
    } access_t;

    localparam int MAX_REGS       = 256;
    localparam int MAX_DATA_WIDTH = 128;

    typedef struct packed {
        logic                      valid;
        logic [MAX_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } rsp_t;

    // The illegal encoding 3 is treated as read-only so a bad map can never corrupt state.
    function automatic access_t acc_of(input logic [2*MAX_REGS-1:0] access, input int idx);
        logic [1:0] f;
        f = access[2*idx +: 2];
        case (f)
            2'd0:    return ACC_RW;
            2'd2:    return ACC_W1C;
            default: return ACC_RO;
        endcase
    endfunction

endpackage

// File: rtl/example_regbank_if.sv
// Valid/ready request/response bus between the register bridge (master) and the bank (slave).
interface example_regbank_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_strb;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_strb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_strb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/example_regbank_cell.sv
// One register of the bank: RW byte-merge, W1C with set-over-clear priority, or RO passthrough.
module example_regbank_cell
    import example_regbank_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter access_t               ACC        = ACC_RW,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0,
    parameter bit                    NO_RST     = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    input  logic [DATA_WIDTH-1:0]   hw_in_i,
    input  logic [DATA_WIDTH-1:0]   hw_set_i,
    output logic [DATA_WIDTH-1:0]   val_o,
    output logic                    wr_pulse_o
);
    localparam int NB = DATA_WIDTH / 8;

    logic pulse_q;
    logic unused_ok;

    // Each access mode leaves some inputs unconnected to logic.
    assign unused_ok = ^{hw_in_i, hw_set_i, wdata_i, strb_i};

    if (ACC == ACC_RO) begin : g_ro
        assign val_o = hw_in_i;
    end else begin : g_store
        logic [DATA_WIDTH-1:0] bmask;
        logic [DATA_WIDTH-1:0] val_d, val_q;

        always_comb begin
            bmask = '0;
            for (int k = 0; k < NB; k++) bmask[k*8 +: 8] = {8{strb_i[k]}};
        end

        always_comb begin
            val_d = val_q;
            if (ACC == ACC_W1C) begin
                if (we_i) val_d = val_q & ~(wdata_i & bmask);
                val_d = val_d | hw_set_i;
            end else if (we_i) begin
                val_d = (val_q & ~bmask) | (wdata_i & bmask);
            end
        end

        if (NO_RST) begin : g_nrst
            always_ff @(posedge clk) val_q <= val_d;
        end else begin : g_rst
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) val_q <= RST_VAL;
                else        val_q <= val_d;
            end
        end

        assign val_o = val_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pulse_q <= 1'b0;
        else        pulse_q <= we_i && (ACC != ACC_RO);
    end

    assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/example_regbank.sv
// Parametrised register bank with a valid/ready bus port and one outstanding response.
// Define REGBANK_ERR_EN to flag out-of-range accesses and RO writes on rsp_err.
module example_regbank
    import example_regbank_pkg::*;
#(
    parameter int                             NUM_REGS      = 8,
    parameter int                             ADDR_WIDTH    = 3,
    parameter int                             DATA_WIDTH    = 32,
    parameter logic [2*NUM_REGS-1:0]          ACCESS        = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE   = '0,
    parameter logic [NUM_REGS-1:0]            NO_RESET_MASK = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    example_regbank_if.slave               bus,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    logic                                 accept;
    logic [NUM_REGS-1:0]                  sel;
    logic [NUM_REGS-1:0]                  we;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs;
    logic [DATA_WIDTH-1:0]                rd_mux;
    logic                                 err_d;
    rsp_t                                 rsp_d, rsp_q;
    logic                                 unused_ok;

    assign bus.req_ready = !rsp_q.valid || bus.rsp_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign sel[i] = (bus.req_addr == ADDR_WIDTH'(i));
        assign we[i]  = accept && bus.req_we && sel[i];

        example_regbank_cell #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC        (acc_of((2*MAX_REGS)'(ACCESS), i)),
            .RST_VAL    (RESET_VALUE[i*DATA_WIDTH +: DATA_WIDTH]),
            .NO_RST     (NO_RESET_MASK[i])
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .we_i       (we[i]),
            .wdata_i    (bus.req_wdata),
            .strb_i     (bus.req_strb),
            .hw_in_i    (hw_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .hw_set_i   (hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
            .val_o      (regs[i]),
            .wr_pulse_o (wr_pulse[i])
        );
    end

    assign regs_out = regs;

    // Out-of-range addresses match no sel bit, so the mux naturally yields zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel[i]) rd_mux = regs[i];
        end
    end

`ifdef REGBANK_ERR_EN
    logic in_range;
    assign in_range = ({1'b0, bus.req_addr} < (ADDR_WIDTH+1)'(NUM_REGS));

    always_comb begin
        err_d = !in_range;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel[i] && bus.req_we && (acc_of((2*MAX_REGS)'(ACCESS), i) == ACC_RO)) err_d = 1'b1;
        end
    end
`else
    assign err_d = 1'b0;
`endif

    always_comb begin
        rsp_d = rsp_q;
        if (accept) begin
            rsp_d.valid = 1'b1;
            rsp_d.rdata = '0;
            if (!bus.req_we) rsp_d.rdata[DATA_WIDTH-1:0] = rd_mux;
            rsp_d.err   = err_d;
        end else if (bus.rsp_ready) begin
            rsp_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp_q <= '0;
        else        rsp_q <= rsp_d;
    end

    assign bus.rsp_valid = rsp_q.valid;
    assign bus.rsp_rdata = rsp_q.rdata[DATA_WIDTH-1:0];
`ifdef REGBANK_ERR_EN
    assign bus.rsp_err   = rsp_q.err;
`else
    assign bus.rsp_err   = 1'b0;
`endif

    // The response record is sized for the widest bank; the spare bits are never read.
    assign unused_ok = ^rsp_q;

endmodule

// File: tb/tb_example_regbank.sv
// Directed plus randomized checks of example_regbank against a per-register behavioural model.
module tb_example_regbank;
    localparam int NR = 8;
    localparam int AW = 4;
    localparam int DW = 32;
    // reg0 RW, 1 RW, 2 W1C, 3 RO, 4 RW, 5 W1C, 6 RO, 7 RW
    localparam logic [2*NR-1:0]  ACC = 16'b00_01_10_00_01_10_00_00;
    localparam logic [NR*DW-1:0] RV  = (256'd12 << 128) | (256'hF << 64);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*DW-1:0] hw_in, hw_set, regs_out;
    logic [NR-1:0]    wr_pulse;

    example_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    example_regbank #(
        .NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ACCESS(ACC), .RESET_VALUE(RV), .NO_RESET_MASK('0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .hw_in(hw_in), .hw_set(hw_set), .regs_out(regs_out), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m [NR];
    int          acc_t [NR]   = '{0, 0, 2, 1, 0, 2, 1, 0};  // 0 RW, 1 RO, 2 W1C
    logic [31:0] rst_val [NR] = '{32'h0, 32'h0, 32'hF, 32'h0, 32'd12, 32'h0, 32'h0, 32'h0};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_regs();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NR; i++)
            v[i*DW +: DW] = (acc_t[i] == 1) ? hw_in[i*DW +: DW] : m[i];
        return v;
    endfunction

    function automatic logic exp_err(input logic we, input int addr);
`ifdef REGBANK_ERR_EN
        return (addr >= NR) || (we && acc_t[addr] == 1);
`else
        return 1'b0;
`endif
    endfunction

    // One accepted request with rsp_ready high; model updated from the spec rules at the accept edge.
    task automatic step(input logic we, input logic [3:0] addr, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0]   e_rd;
        logic          e_er;
        logic [NR-1:0] e_pl;
        logic [31:0]   mask;
        int            a;
        a = int'(addr);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
        bus.req_wdata = wd;   bus.req_strb = st; bus.rsp_ready = 1'b1;
        @(posedge clk);
        e_rd = '0; e_pl = '0;
        e_er = exp_err(we, a);
        if (a < NR && !we) e_rd = (acc_t[a] == 1) ? hw_in[a*DW +: DW] : m[a];
        for (int k = 0; k < 4; k++) mask[k*8 +: 8] = {8{st[k]}};
        if (we && a < NR) begin
            if (acc_t[a] == 0) begin
                m[a] = (m[a] & ~mask) | (wd & mask); e_pl[a] = 1'b1;
            end else if (acc_t[a] == 2) begin
                m[a] = m[a] & ~(wd & mask); e_pl[a] = 1'b1;
            end
        end
        for (int i = 0; i < NR; i++)
            if (acc_t[i] == 2) m[i] = m[i] | hw_set[i*DW +: DW];
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rsp_valid", 256'(bus.rsp_valid), 256'd1);
        chk("rsp_rdata", 256'(bus.rsp_rdata), 256'(e_rd));
        chk("rsp_err",   256'(bus.rsp_err),   256'(e_er));
        chk("wr_pulse",  256'(wr_pulse),      256'(e_pl));
        chk("regs_out",  regs_out,            exp_regs());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_strb = '0; bus.rsp_ready = 1'b1;
        hw_in = '0; hw_set = '0;
        for (int i = 0; i < NR; i++) m[i] = rst_val[i];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_req_ready", 256'(bus.req_ready), 256'd1);
        chk("rst_rsp_valid", 256'(bus.rsp_valid), 256'd0);
        chk("rst_rsp_rdata", 256'(bus.rsp_rdata), 256'd0);
        chk("rst_rsp_err",   256'(bus.rsp_err),   256'd0);
        chk("rst_wr_pulse",  256'(wr_pulse),      256'd0);
        chk("rst_regs",      regs_out,            exp_regs());

        step(1'b0, 4'd4, '0, '0);
        chk("rd4_reset", 256'(bus.rsp_rdata), 256'd12);

        step(1'b1, 4'd0, 32'hAABBCCDD, 4'b0101);
        chk("wr0_pulse", 256'(wr_pulse), 256'h01);
        step(1'b0, 4'd0, '0, '0);
        chk("rd0_strb", 256'(bus.rsp_rdata), 256'h00BB00DD);
        chk("wr0_pulse_drop", 256'(wr_pulse), 256'd0);

        hw_set[2*DW +: DW] = 32'h10;
        step(1'b1, 4'd2, 32'h11, 4'b0001);
        hw_set = '0;
        chk("w1c_set_wins", 256'(regs_out[2*DW +: DW]), 256'h1E);

        hw_in[3*DW +: DW] = 32'h1234;
        step(1'b1, 4'd3, 32'hFFFF, 4'hF);
        chk("ro_no_pulse", 256'(wr_pulse), 256'd0);
        step(1'b0, 4'd3, '0, '0);
        chk("ro_read", 256'(bus.rsp_rdata), 256'h1234);

        // Backpressure: a pending read waits while the held response stays stable.
        step(1'b0, 4'd4, '0, '0);
        bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd0;
        #1;
        chk("bp_req_ready", 256'(bus.req_ready), 256'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            chk("bp_rsp_valid", 256'(bus.rsp_valid), 256'd1);
            chk("bp_rsp_hold",  256'(bus.rsp_rdata), 256'd12);
            chk("bp_req_ready", 256'(bus.req_ready), 256'd0);
        end
        step(1'b0, 4'd0, '0, '0);
        step(1'b0, 4'd4, '0, '0);
        step(1'b0, 4'd1, '0, '0);

        step(1'b0, 4'd9, '0, '0);
        step(1'b1, 4'd9, 32'hFFFF_FFFF, 4'hF);

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = $urandom;
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < NR; i++) hw_set[i*DW +: DW] = $urandom & $urandom;
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), $urandom, 4'($urandom));
            hw_set = '0;
        end

        // Reset with a response outstanding drops rsp_valid without waiting for a clock.
        step(1'b0, 4'd4, '0, '0);
        bus.rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_rsp_valid", 256'(bus.rsp_valid), 256'd0);
        chk("rstmid_req_ready", 256'(bus.req_ready), 256'd1);
        chk("rstmid_wr_pulse",  256'(wr_pulse),      256'd0);
        for (int i = 0; i < NR; i++) m[i] = rst_val[i];
        chk("rstmid_regs", regs_out, exp_regs());
        @(negedge clk);
        rst_n = 1'b1; bus.rsp_ready = 1'b1;
        @(negedge clk);
        step(1'b0, 4'd0, '0, '0);
        step(1'b0, 4'd2, '0, '0);
        chk("rstmid_rd2", 256'(bus.rsp_rdata), 256'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
